// File: rtl/camo_key_array.sv
// Array of 2-key-bit camouflaged cells with a serially loaded, parity-checked key.
// Define CAMO_OUT_REG_EN to register y_vec (1-cycle latency, resets to 0).
module camo_key_array #(
  parameter int NUM_CELLS  = 6,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 key_start,
  input  logic                                 key_valid,
  input  logic                                 key_bit,
  input  logic [NUM_CELLS-1:0]                 a_vec,
  input  logic [NUM_CELLS-1:0]                 b_vec,
  output logic [NUM_CELLS-1:0]                 y_vec,
  output logic                                 key_locked,
  output logic                                 key_err,
  output logic                                 busy,
  output logic [$clog2(2*NUM_CELLS+2)-1:0]     bit_cnt
);

  localparam int KEY_W = 2 * NUM_CELLS;
  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam logic [CNT_W-1:0] KEY_W_CNT = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOCKED, ERROR} state_t;

  state_t             state;
  logic [KEY_W-1:0]   shadow;
  logic [KEY_W-1:0]   active_key;
  logic               parity;
  logic [NUM_CELLS-1:0] y_comb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      active_key <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      key_locked <= 1'b0;
      key_err    <= 1'b0;
      busy       <= 1'b0;
    end else if (key_start) begin
      // A restart from any state keeps the previously committed key live.
      state      <= SHIFT;
      shadow     <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      key_locked <= 1'b0;
      key_err    <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (key_valid) begin
            parity  <= parity ^ key_bit;
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt < KEY_W_CNT) begin
              shadow <= {key_bit, shadow[KEY_W-1:1]};
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          busy <= 1'b0;
          if (parity == PARITY_ODD) begin
            active_key <= shadow;
            key_locked <= 1'b1;
            state      <= LOCKED;
          end else begin
            active_key <= '0;
            key_err    <= 1'b1;
            state      <= ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    y_comb = '1;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (active_key[2*i])
        y_comb[i] = a_vec[i] ^ b_vec[i];
      else if (active_key[2*i+1])
        y_comb[i] = ~(a_vec[i] | b_vec[i]);
      else
        y_comb[i] = ~(a_vec[i] & b_vec[i]);
    end
  end

`ifdef CAMO_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_vec <= '0;
    else     y_vec <= y_comb;
  end
`else
  assign y_vec = y_comb;
`endif

endmodule
